// File: rtl/reg_file_param.sv
// DEPTH x WIDTH register file: two combinational read ports (optional write bypass, optional
// zero register), per-bit Z/V/N flags, and a DEPTH-cycle soft clear during which writes are dropped.
module reg_file_param #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 16,
   parameter bit ZERO_REG = 1'b0,
   parameter bit BYPASS   = 1'b1,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    SrcReg1,
   input  logic [AW-1:0]    SrcReg2,
   input  logic [AW-1:0]    DstReg,
   input  logic             WriteReg,
   input  logic [WIDTH-1:0] DstData,
   output logic [WIDTH-1:0] SrcData1,
   output logic [WIDTH-1:0] SrcData2,
   input  logic [2:0]       FlagD,
   input  logic [2:0]       FlagWen,
   output logic [2:0]       Flags,
   input  logic             clr_req,
   output logic             busy,
   output logic             wr_drop
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [AW-1:0]    clr_idx_q, clr_idx_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [2:0]       flags_q, flags_d;
   logic             wr_acc;
   logic             wr_eff;

   assign busy    = (state_q == ST_CLEAR);
   assign wr_acc  = WriteReg & ~busy;
   assign wr_drop = WriteReg & busy;
   assign Flags   = flags_q;

   // A write to the hardwired zero register is accepted but must not touch storage.
   assign wr_eff  = wr_acc & ~(ZERO_REG && (DstReg == '0));

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      unique case (state_q)
         ST_IDLE: begin
            if (clr_req) begin
               state_d   = ST_CLEAR;
               clr_idx_d = '0;
            end
         end
         ST_CLEAR: begin
            // DEPTH is a power of two, so the increment wraps to 0 on the last entry.
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == AW'(DEPTH - 1)) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            clr_idx_d = '0;
         end
      endcase
   end

   always_comb begin
      mem_d = mem_q;
      if (busy) begin
         mem_d[clr_idx_q] = '0;
      end else if (wr_eff) begin
         mem_d[DstReg] = DstData;
      end
   end

   assign flags_d = (flags_q & ~FlagWen) | (FlagD & FlagWen);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         clr_idx_q <= '0;
         flags_q   <= '0;
         mem_q     <= '{default: '0};
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
         flags_q   <= flags_d;
         mem_q     <= mem_d;
      end
   end

   // Zero register overrides bypass; bypass only fires for an accepted write.
   always_comb begin
      SrcData1 = mem_q[SrcReg1];
      if (BYPASS && wr_acc && (DstReg == SrcReg1)) begin
         SrcData1 = DstData;
      end
      if (ZERO_REG && (SrcReg1 == '0)) begin
         SrcData1 = '0;
      end
   end

   always_comb begin
      SrcData2 = mem_q[SrcReg2];
      if (BYPASS && wr_acc && (DstReg == SrcReg2)) begin
         SrcData2 = DstData;
      end
      if (ZERO_REG && (SrcReg2 == '0)) begin
         SrcData2 = '0;
      end
   end

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: instance A (defaults) and instance B (ZERO_REG=1, BYPASS=0) share stimulus.
`timescale 1ns/1ps
module tb_reg_file_param;
   localparam int D = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  src1, src2, dst;
   logic        wr;
   logic [15:0] dat;
   logic [2:0]  flag_d, flag_wen;
   logic        clr_req;
   logic [15:0] s1_a, s2_a, s1_b, s2_b;
   logic [2:0]  flags_a, flags_b;
   logic        busy_a, busy_b, drop_a, drop_b;

   int checks   = 0;
   int failures = 0;

   // Reference model: storage per instance, flags, and clear progress.
   logic [15:0] mdl_a [D];
   logic [15:0] mdl_b [D];
   logic [2:0]  mdl_flags;
   bit          mdl_busy;
   int          mdl_pos;

   always #5 clk = ~clk;

   reg_file_param u_a (
      .clk(clk), .rst(rst), .SrcReg1(src1), .SrcReg2(src2), .DstReg(dst), .WriteReg(wr),
      .DstData(dat), .SrcData1(s1_a), .SrcData2(s2_a), .FlagD(flag_d), .FlagWen(flag_wen),
      .Flags(flags_a), .clr_req(clr_req), .busy(busy_a), .wr_drop(drop_a)
   );

   reg_file_param #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_b (
      .clk(clk), .rst(rst), .SrcReg1(src1), .SrcReg2(src2), .DstReg(dst), .WriteReg(wr),
      .DstData(dat), .SrcData1(s1_b), .SrcData2(s2_b), .FlagD(flag_d), .FlagWen(flag_wen),
      .Flags(flags_b), .clr_req(clr_req), .busy(busy_b), .wr_drop(drop_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic void mdl_reset();
      for (int i = 0; i < D; i++) begin
         mdl_a[i] = 16'h0;
         mdl_b[i] = 16'h0;
      end
      mdl_flags = 3'b000;
      mdl_busy  = 1'b0;
      mdl_pos   = 0;
   endfunction

   // Instance B has the zero register and no bypass; instance A has bypass only.
   function automatic logic [15:0] exp_rd(input bit inst_b, input logic [3:0] a);
      bit acc;
      acc = wr && !mdl_busy;
      if (inst_b) begin
         if (a == 4'd0) return 16'h0;
         return mdl_b[a];
      end
      if (acc && dst == a) return dat;
      return mdl_a[a];
   endfunction

   task automatic check_outputs();
      chk("rd1_a",  32'(s1_a),    32'(exp_rd(1'b0, src1)));
      chk("rd2_a",  32'(s2_a),    32'(exp_rd(1'b0, src2)));
      chk("rd1_b",  32'(s1_b),    32'(exp_rd(1'b1, src1)));
      chk("rd2_b",  32'(s2_b),    32'(exp_rd(1'b1, src2)));
      chk("flg_a",  32'(flags_a), 32'(mdl_flags));
      chk("flg_b",  32'(flags_b), 32'(mdl_flags));
      chk("busy_a", 32'(busy_a),  32'(mdl_busy));
      chk("busy_b", 32'(busy_b),  32'(mdl_busy));
      chk("drop_a", 32'(drop_a),  32'(wr && mdl_busy));
      chk("drop_b", 32'(drop_b),  32'(wr && mdl_busy));
   endtask

   task automatic mdl_step();
      if (rst) return;
      for (int i = 0; i < 3; i++) begin
         if (flag_wen[i]) mdl_flags[i] = flag_d[i];
      end
      if (mdl_busy) begin
         mdl_a[mdl_pos] = 16'h0;
         mdl_b[mdl_pos] = 16'h0;
         mdl_pos++;
         if (mdl_pos == D) begin
            mdl_busy = 1'b0;
            mdl_pos  = 0;
         end
      end else begin
         if (wr) begin
            mdl_a[dst] = dat;
            if (dst != 4'd0) mdl_b[dst] = dat;
         end
         if (clr_req) begin
            mdl_busy = 1'b1;
            mdl_pos  = 0;
         end
      end
   endtask

   // Inputs change at posedge+1; outputs are compared at the following negedge.
   task automatic tick();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      mdl_step();
      #1;
   endtask

   task automatic read_all(input bit expect_zero);
      wr = 1'b0;
      for (int a = 0; a < D; a++) begin
         src1 = 4'(a);
         src2 = 4'(D - 1 - a);
         if (expect_zero) begin
            #3;
            chk("zero_rd1", 32'(s1_a), 32'h0);
            chk("zero_rd2", 32'(s2_a), 32'h0);
         end
         tick();
      end
   endtask

   initial begin
      int n;
      rst = 1'b1; src1 = '0; src2 = '0; dst = '0; wr = 1'b0; dat = '0;
      flag_d = '0; flag_wen = '0; clr_req = 1'b0;
      mdl_reset();
      #1;
      tick();
      rst = 1'b0;

      // Reset state on every address
      read_all(1'b1);

      // Bypass vs. registered read
      wr = 1'b1; dst = 4'd3; dat = 16'hBEEF; src1 = 4'd3; src2 = 4'd0;
      #3;
      chk("bypass_a", 32'(s1_a), 32'hBEEF);
      chk("nobyp_b",  32'(s1_b), 32'h0);
      tick();
      wr = 1'b0; src2 = 4'd3;
      #3;
      chk("later_a", 32'(s2_a), 32'hBEEF);
      chk("later_b", 32'(s2_b), 32'hBEEF);
      tick();

      // Zero register
      wr = 1'b1; dst = 4'd0; dat = 16'h1234; src1 = 4'd0; src2 = 4'd0;
      #3;
      chk("zr_same1", 32'(s1_b), 32'h0);
      chk("zr_same2", 32'(s2_b), 32'h0);
      tick();
      wr = 1'b0;
      #3;
      chk("zr_later", 32'(s1_b), 32'h0);
      chk("r0_a",     32'(s1_a), 32'h1234);
      tick();

      // Fill, soft clear, dropped write during busy
      for (int i = 0; i < D; i++) begin
         wr = 1'b1; dst = 4'(i); dat = 16'(16'h1000 + i);
         tick();
      end
      wr = 1'b0; clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         if (!busy_a) break;
         if (n == 10) begin
            wr = 1'b1; dst = 4'd5; dat = 16'hAAAA; src1 = 4'd5;
            #3;
            chk("wr_drop",  32'(drop_a), 32'h1);
            chk("no_byp_busy", 32'(s1_a), 32'h0);
         end else begin
            wr = 1'b0;
         end
         n++;
         tick();
      end
      chk("busy_len", 32'(n), 32'd16);
      read_all(1'b1);

      // Flags with per-bit enable, then reset mid-clear
      flag_d = 3'b111; flag_wen = 3'b010;
      tick();
      flag_wen = 3'b000;
      #3;
      chk("flag_010", 32'(flags_a), 32'h2);
      tick();
      wr = 1'b1; dst = 4'd10; dat = 16'h0A0A; flag_d = 3'b101; flag_wen = 3'b111;
      tick();
      dst = 4'd12; dat = 16'h0C0C; flag_wen = 3'b000;
      tick();
      wr = 1'b0; clr_req = 1'b1;
      tick();
      clr_req = 1'b0; src1 = 4'd10; src2 = 4'd12;
      repeat (6) tick();
      #3;
      chk("pre_rst_r10", 32'(s1_a), 32'h0A0A);
      rst = 1'b1;
      mdl_reset();
      #1;
      chk("rst_busy",  32'(busy_a),  32'h0);
      chk("rst_r10",   32'(s1_a),    32'h0);
      chk("rst_r12",   32'(s2_a),    32'h0);
      chk("rst_flags", 32'(flags_a), 32'h0);
      read_all(1'b1);
      rst = 1'b0;
      tick();

      // Write and clear request in the same idle cycle
      wr = 1'b1; dst = 4'd9; dat = 16'h5555; clr_req = 1'b1; src1 = 4'd9;
      tick();
      wr = 1'b0; clr_req = 1'b0;
      #3;
      chk("r9_commit", 32'(s1_a), 32'h5555);
      for (int k = 0; k < 40; k++) begin
         if (!busy_a) break;
         tick();
      end
      chk("clr_done", 32'(busy_a), 32'h0);
      #1;
      chk("r9_cleared", 32'(s1_a), 32'h0);
      tick();

      // Randomized traffic against the model
      repeat (400) begin
         src1     = 4'($urandom_range(0, 15));
         src2     = 4'($urandom_range(0, 15));
         dst      = 4'($urandom_range(0, 15));
         wr       = 1'($urandom_range(0, 1));
         dat      = 16'($urandom);
         flag_d   = 3'($urandom_range(0, 7));
         flag_wen = 3'($urandom_range(0, 7));
         clr_req  = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 149) == 0) begin
            rst = 1'b1;
            mdl_reset();
         end else begin
            rst = 1'b0;
         end
         tick();
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
